counter_mod: RTL



---
 rtl/counter_mod.sv | 108 ++++++++++
 1 files changed

// File: rtl/counter_mod.sv
// counter_mod: parametrised up/down modulo counter with programmable terminal
// value, direction control, count enable, synchronous load, a wrap-event pulse
// and a sticky overflow flag.
//
// Optional build macro: COUNTER_MOD_SATURATE_EN
//   undefined : the counter wraps at its boundaries (0 <-> max_i)
//   defined   : the counter saturates at its boundaries and wrap_o stays 0
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset
//   clr_i       synchronous clear (count -> RST_VAL, ovf -> 0)
//   en_i        count enable, one step per cycle
//   up_i        direction, 1 = increment, 0 = decrement
//   load_i      synchronous load of load_val_i (beats en_i)
//   load_val_i  value to load, no range check
//   max_i       terminal value, count range is 0..max_i
//   count_o     registered count
//   wrap_o      registered one-cycle pulse following a wrap event
//   ovf_o       sticky overflow, cleared by rst_i or clr_i only
module counter_mod #(
  parameter int unsigned    BW      = 8,
  parameter logic [BW-1:0]  RST_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          up_i,
  input  logic          load_i,
  input  logic [BW-1:0] load_val_i,
  input  logic [BW-1:0] max_i,
  output logic [BW-1:0] count_o,
  output logic          wrap_o,
  output logic          ovf_o
);

  localparam logic [BW-1:0] ONE  = BW'(1);
  localparam logic [BW-1:0] ZERO = '0;

  logic [BW-1:0] count_q, count_d;
  logic          wrap_q,  wrap_d;
  logic          ovf_q,   ovf_d;

  // Next-state: clr > load > en > hold (reset handled in the register).
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;

    if (clr_i) begin
      count_d = RST_VAL;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        // >= also catches a count loaded above max_i.
        if (count_q >= max_i) begin
`ifdef COUNTER_MOD_SATURATE_EN
          count_d = max_i;
          ovf_d   = 1'b1;
`else
          count_d = ZERO;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
`endif
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == ZERO) begin
`ifdef COUNTER_MOD_SATURATE_EN
          count_d = ZERO;
          ovf_d   = 1'b1;
`else
          count_d = max_i;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
`endif
        end else if (count_q > max_i) begin
          // Out-of-range count re-enters the range at the top, not a wrap.
          count_d = max_i;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign ovf_o   = ovf_q;

endmodule
